// File: rtl/universal_shift_reg_burst_pkg.sv
// Shared op-select codes and burst FSM state encoding for the universal shift register.
package universal_shift_reg_burst_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHR   = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_LOAD  = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_ASR   = 3'd6;
  localparam logic [2:0] MODE_BURST = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/universal_shift_reg_burst_ctrl.sv
// Burst sequencer: accepts a burst request, counts shifts down and raises a one-cycle done pulse.
module universal_shift_reg_burst_ctrl
  import universal_shift_reg_burst_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir_in,
  output logic             shift_en,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && amt != '0)       state_d = ST_BURST;
      ST_BURST: if (cnt_q == AMT_W'(1))       state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // A zero-length request completes immediately without ever entering BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (amt != '0) begin
              cnt_q <= amt;
              dir_q <= dir_in;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          cnt_q <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shift_en = (state_q == ST_BURST);
    busy     = (state_q == ST_BURST);
    dir      = dir_q;
    done     = done_q;
  end

endmodule

// File: rtl/universal_shift_reg_burst.sv
// Universal shift register: single-cycle shift/rotate/load ops plus a sequenced multi-cycle burst shift.
module universal_shift_reg_burst
  import universal_shift_reg_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic             burst_dir,
  input  logic [AMT_W-1:0] burst_amt,
  output logic [WIDTH-1:0] data_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  function automatic logic [WIDTH-1:0] asr1(input logic [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] s;
    s = d;
    return s >>> 1;
  endfunction

  logic             shift_en;
  logic             shift_dir;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] data_p1;

  universal_shift_reg_burst_ctrl #(.AMT_W(AMT_W)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (mode == MODE_BURST),
    .amt      (burst_amt),
    .dir_in   (burst_dir),
    .shift_en (shift_en),
    .dir      (shift_dir),
    .busy     (busy),
    .done     (done)
  );

  // Stage p0: next-value mux; mode is ignored whenever a burst owns the register.
  always_comb begin
    data_p0 = data_p1;
    if (shift_en) begin
      data_p0 = shift_dir ? {data_p1[WIDTH-2:0], lsb_in} : {msb_in, data_p1[WIDTH-1:1]};
    end else if (!busy) begin
      case (mode)
        MODE_HOLD:  data_p0 = data_p1;
        MODE_SHR:   data_p0 = {msb_in, data_p1[WIDTH-1:1]};
        MODE_SHL:   data_p0 = {data_p1[WIDTH-2:0], lsb_in};
        MODE_LOAD:  data_p0 = data_in;
        MODE_ROR:   data_p0 = {data_p1[0], data_p1[WIDTH-1:1]};
        MODE_ROL:   data_p0 = {data_p1[WIDTH-2:0], data_p1[WIDTH-1]};
        MODE_ASR:   data_p0 = asr1(data_p1);
        MODE_BURST: data_p0 = data_p1;
      endcase
    end
  end

  // Stage p1: register contents.
  always_ff @(posedge clk) begin
    if (rst) data_p1 <= '0;
    else     data_p1 <= data_p0;
  end

  assign data_out = data_p1;
  assign msb_out  = data_p1[WIDTH-1];
  assign lsb_out  = data_p1[0];

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// Bench for universal_shift_reg_burst: vector table, burst corner sequences and random ops vs a reference model.
module tb_universal_shift_reg_burst;

  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   mode;
  logic [W-1:0] data_in;
  logic         msb_in, lsb_in, burst_dir;
  logic [A-1:0] burst_amt;
  logic [W-1:0] data_out;
  logic         msb_out, lsb_out, busy, done;

  universal_shift_reg_burst #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .rst(rst), .mode(mode), .data_in(data_in), .msb_in(msb_in),
    .lsb_in(lsb_in), .burst_dir(burst_dir), .burst_amt(burst_amt),
    .data_out(data_out), .msb_out(msb_out), .lsb_out(lsb_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register value plus number of burst shifts still owed.
  int m_data = 0;
  int m_rem  = 0;
  int m_dir  = 0;
  int m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_data = 0; m_rem = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_rem > 0) begin
      if (m_dir == 1) m_data = ((m_data * 2) % 256) + lsb_in;
      else            m_data = (m_data / 2) + (msb_in ? 128 : 0);
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end else begin
      case (mode)
        3'd1: m_data = (m_data / 2) + (msb_in ? 128 : 0);
        3'd2: m_data = ((m_data * 2) % 256) + lsb_in;
        3'd3: m_data = data_in;
        3'd4: m_data = (m_data / 2) + ((m_data % 2) * 128);
        3'd5: m_data = ((m_data * 2) % 256) + (m_data / 128);
        3'd6: m_data = (m_data / 2) + (m_data >= 128 ? 128 : 0);
        3'd7: begin
          if (burst_amt == 0) m_done = 1;
          else begin m_rem = burst_amt; m_dir = burst_dir; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "_data"}, data_out, m_data);
    chk({tag, "_busy"}, busy, (m_rem > 0) ? 1 : 0);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_msb"}, msb_out, (m_data >= 128) ? 1 : 0);
    chk({tag, "_lsb"}, lsb_out, m_data % 2);
  endtask

  task automatic drive(input logic [2:0] m, input logic [7:0] d, input logic mi, input logic li);
    mode = m; data_in = d; msb_in = mi; lsb_in = li;
  endtask

  typedef struct {
    logic [2:0] mode;
    logic [7:0] din;
    logic       msb;
    logic       lsb;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];
  int   done_cnt, busy_cnt;

  initial begin
    vecs[0]  = '{3'd3, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{3'd0, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[2]  = '{3'd0, 8'h3C, 1'b1, 1'b1, 8'hA5};
    vecs[3]  = '{3'd0, 8'hFF, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{3'd3, 8'h80, 1'b0, 1'b0, 8'h80};
    vecs[5]  = '{3'd6, 8'h00, 1'b0, 1'b0, 8'hC0};
    vecs[6]  = '{3'd3, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[7]  = '{3'd5, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[8]  = '{3'd4, 8'h00, 1'b0, 1'b0, 8'h81};
    vecs[9]  = '{3'd3, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{3'd2, 8'h00, 1'b0, 1'b1, 8'h01};
    vecs[11] = '{3'd1, 8'h00, 1'b1, 1'b0, 8'h80};
    vecs[12] = '{3'd2, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{3'd1, 8'h00, 1'b0, 1'b0, 8'h00};

    rst = 1'b1; burst_dir = 1'b0; burst_amt = '0;
    drive(3'd3, 8'hFF, 1'b1, 1'b1);
    cycle("reset");
    chk("reset_data_const", data_out, 0);
    chk("reset_busy_const", busy, 0);
    chk("reset_done_const", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].mode, vecs[i].din, vecs[i].msb, vecs[i].lsb);
      cycle("vec");
      chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
      chk($sformatf("vec%0d_msb", i), msb_out, vecs[i].exp[7]);
      chk($sformatf("vec%0d_lsb", i), lsb_out, vecs[i].exp[0]);
    end

    // Burst right by 3 from 0xA5 while a LOAD 0xFF is presented and must be ignored.
    drive(3'd3, 8'hA5, 1'b0, 1'b0);
    cycle("pre_burst");
    drive(3'd7, 8'h00, 1'b0, 1'b0); burst_dir = 1'b0; burst_amt = 4'd3;
    cycle("accept");
    chk("accept_data_const", data_out, 8'hA5);
    done_cnt = 0; busy_cnt = busy;
    drive(3'd3, 8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle("burst");
      busy_cnt += busy; done_cnt += done;
      if (k < 2) chk("burst_done_early", done, 0);
    end
    chk("burst_result", data_out, 8'h14);
    chk("burst_done_at_n", done, 1);
    chk("burst_busy_cycles", busy_cnt, 3);
    drive(3'd0, 8'h00, 1'b0, 1'b0);
    cycle("post_burst");
    done_cnt += done;
    chk("burst_done_pulses", done_cnt, 1);

    // Zero-length burst.
    drive(3'd7, 8'h00, 1'b0, 1'b0); burst_amt = 4'd0;
    cycle("amt0");
    chk("amt0_busy", busy, 0);
    chk("amt0_done", done, 1);
    chk("amt0_data", data_out, 8'h14);
    drive(3'd0, 8'h00, 1'b0, 1'b0);
    cycle("amt0_after");
    chk("amt0_done_clear", done, 0);

    // Burst left with lsb fill 1 from 0x81.
    drive(3'd3, 8'h81, 1'b0, 1'b1);
    cycle("pre_left");
    drive(3'd7, 8'h00, 1'b0, 1'b1); burst_dir = 1'b1; burst_amt = 4'd2;
    cycle("left_accept");
    cycle("left_1");
    cycle("left_2");
    chk("left_result", data_out, 8'h07);

    // Reset aborts a burst in progress.
    drive(3'd7, 8'h00, 1'b1, 1'b0); burst_dir = 1'b0; burst_amt = 4'd5;
    cycle("abort_accept");
    drive(3'd0, 8'h00, 1'b1, 1'b0);
    cycle("abort_1");
    rst = 1'b1;
    cycle("abort_rst");
    chk("abort_data", data_out, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle("abort_quiet");
      done_cnt += done;
    end
    chk("abort_no_done", done_cnt, 0);
    drive(3'd3, 8'h3C, 1'b0, 1'b0);
    cycle("abort_load");
    chk("abort_load_data", data_out, 8'h3C);

    // Random ops against the model.
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = 3'($urandom_range(0, 7));
      data_in   = 8'($urandom);
      msb_in    = 1'($urandom);
      lsb_in    = 1'($urandom);
      burst_dir = 1'($urandom);
      burst_amt = 4'($urandom);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
